sram_arbiter: RTL and testbench

//  Shares one SRAM port (the registered SRAM control block) between the instruction-fetch (IF) and

---
 rtl/sram_arbiter_if.sv | 45 ++++
 rtl/sram_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester, SRAM control block and status signals shared by one arbiter instance.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = 4
);
    // Instruction-fetch requester
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_DONE;
    logic [DATA_W-1:0] IF_RDATA;

    // Data-memory requester
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [BE_W-1:0]   MEM_BE_N;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_DONE;
    logic [DATA_W-1:0] MEM_RDATA;

    // SRAM control block (*_I inputs) and its read data
    logic              RAM_CE_N;
    logic              RAM_WE_N;
    logic [BE_W-1:0]   RAM_BE_N;
    logic [ADDR_W-1:0] RAM_PADDR;
    logic [DATA_W-1:0] RAM_WDATA;
    logic [DATA_W-1:0] RAM_RDATA;

    logic              BUSY;

    // Arbiter side
    modport slave (
        input  IF_REQ, IF_ADDR, MEM_REQ, MEM_WE, MEM_BE_N, MEM_ADDR, MEM_WDATA, RAM_RDATA,
        output IF_DONE, IF_RDATA, MEM_DONE, MEM_RDATA,
        output RAM_CE_N, RAM_WE_N, RAM_BE_N, RAM_PADDR, RAM_WDATA, BUSY
    );

    // Environment side: requesters plus the control block
    modport master (
        output IF_REQ, IF_ADDR, MEM_REQ, MEM_WE, MEM_BE_N, MEM_ADDR, MEM_WDATA, RAM_RDATA,
        input  IF_DONE, IF_RDATA, MEM_DONE, MEM_RDATA,
        input  RAM_CE_N, RAM_WE_N, RAM_BE_N, RAM_PADDR, RAM_WDATA, BUSY
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one registered SRAM control block between the IF and MEM requesters.
// Each access is IDLE (grant, drive RAM_*) -> ACCESS (capture read data) -> RESP (DONE pulse).
module sram_arbiter #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = 4,
    parameter bit          RR_EN  = 1'b0
) (
    input logic            CLK,
    input logic            RST,
    sram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              grant_mem_q, grant_mem_d;  // 1: MEM owns the current access
    logic              we_q, we_d;                // latched op type of the current access
    logic              last_mem_q, last_mem_d;    // 1: MEM was granted most recently
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              sel_mem;
    logic              sel_if;

    // Pick a winner in IDLE; a tie goes to MEM unless round-robin says IF's turn.
    always_comb begin
        sel_mem = 1'b0;
        sel_if  = 1'b0;
        if (state_q == StIdle && !RST) begin
            if (bus.MEM_REQ && (!bus.IF_REQ || !RR_EN || !last_mem_q)) begin
                sel_mem = 1'b1;
            end else if (bus.IF_REQ) begin
                sel_if = 1'b1;
            end
        end
    end

    // Next state, grant latching and SRAM/DONE outputs.
    always_comb begin
        state_d       = state_q;
        grant_mem_d   = grant_mem_q;
        we_d          = we_q;
        last_mem_d    = last_mem_q;
        bus.RAM_CE_N  = 1'b1;
        bus.RAM_WE_N  = 1'b1;
        bus.RAM_BE_N  = '1;
        bus.RAM_PADDR = '0;
        bus.RAM_WDATA = '0;
        bus.IF_DONE   = 1'b0;
        bus.MEM_DONE  = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel_mem) begin
                    bus.RAM_CE_N  = 1'b0;
                    bus.RAM_WE_N  = ~bus.MEM_WE;
                    bus.RAM_BE_N  = bus.MEM_BE_N;
                    bus.RAM_PADDR = bus.MEM_ADDR;
                    bus.RAM_WDATA = bus.MEM_WDATA;
                    grant_mem_d   = 1'b1;
                    we_d          = bus.MEM_WE;
                    last_mem_d    = 1'b1;
                    state_d       = StAccess;
                end else if (sel_if) begin
                    bus.RAM_CE_N  = 1'b0;
                    bus.RAM_BE_N  = '0;
                    bus.RAM_PADDR = bus.IF_ADDR;
                    grant_mem_d   = 1'b0;
                    we_d          = 1'b0;
                    last_mem_d    = 1'b0;
                    state_d       = StAccess;
                end
            end
            StAccess: begin
                // Control block is presenting the access; deassert so WE is low one cycle only.
                state_d = StResp;
            end
            StResp: begin
                bus.IF_DONE  = ~grant_mem_q;
                bus.MEM_DONE = grant_mem_q;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register plus read-data capture at the end of ACCESS.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            grant_mem_q <= 1'b0;
            we_q        <= 1'b0;
            last_mem_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_mem_q <= grant_mem_d;
            we_q        <= we_d;
            last_mem_q  <= last_mem_d;
            if (state_q == StAccess && !we_q) begin
                if (grant_mem_q) begin
                    mem_rdata_q <= bus.RAM_RDATA;
                end else begin
                    if_rdata_q <= bus.RAM_RDATA;
                end
            end
        end
    end

    assign bus.IF_RDATA  = if_rdata_q;
    assign bus.MEM_RDATA = mem_rdata_q;
    assign bus.BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a fixed-priority and a round-robin instance, each behind a model of
// the registered SRAM control block and a 256-word SRAM.
module tb_sram_arbiter;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    sram_arbiter_if #(.ADDR_W(19), .DATA_W(32), .BE_W(4)) bus0 ();
    sram_arbiter_if #(.ADDR_W(19), .DATA_W(32), .BE_W(4)) bus1 ();

    sram_arbiter #(.ADDR_W(19), .DATA_W(32), .BE_W(4), .RR_EN(1'b0)) dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    sram_arbiter #(.ADDR_W(19), .DATA_W(32), .BE_W(4), .RR_EN(1'b1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control-block model: registers RAM_* at each edge, SRAM read data follows the pins.
    logic        cen [2];
    logic        wen [2];
    logic [3:0]  ben [2];
    logic [18:0] pad [2];
    logic [31:0] wdt [2];
    logic        cen_q [2];
    logic        wen_q [2];
    logic [3:0]  ben_q [2];
    logic [18:0] pad_q [2];
    logic [31:0] wdt_q [2];
    logic [31:0] rdt [2];
    logic [31:0] mem [2][256];

    assign cen[0] = bus0.RAM_CE_N;
    assign wen[0] = bus0.RAM_WE_N;
    assign ben[0] = bus0.RAM_BE_N;
    assign pad[0] = bus0.RAM_PADDR;
    assign wdt[0] = bus0.RAM_WDATA;
    assign cen[1] = bus1.RAM_CE_N;
    assign wen[1] = bus1.RAM_WE_N;
    assign ben[1] = bus1.RAM_BE_N;
    assign pad[1] = bus1.RAM_PADDR;
    assign wdt[1] = bus1.RAM_WDATA;
    assign bus0.RAM_RDATA = rdt[0];
    assign bus1.RAM_RDATA = rdt[1];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rdt[k] = '0;
            if (!cen_q[k]) rdt[k] = mem[k][pad_q[k][7:0]];
        end
    end

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                cen_q[k] <= 1'b1;
                wen_q[k] <= 1'b1;
                ben_q[k] <= 4'hF;
                pad_q[k] <= '0;
                wdt_q[k] <= '0;
                for (int i = 0; i < 256; i++) mem[k][i] <= '0;
                mem[k][8'h10] <= 32'hDEADBEEF;
                mem[k][8'h20] <= 32'hAABBCCDD;
            end else begin
                if (!cen_q[k] && !wen_q[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (!ben_q[k][b]) mem[k][pad_q[k][7:0]][8*b +: 8] <= wdt_q[k][8*b +: 8];
                    end
                end
                cen_q[k] <= cen[k];
                wen_q[k] <= wen[k];
                ben_q[k] <= ben[k];
                pad_q[k] <= pad[k];
                wdt_q[k] <= wdt[k];
            end
        end
    end

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  be_n;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic        exp_we_n;
        logic [3:0]  exp_be_n;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One single-requester access on dut0, starting just after an edge; no idle gap afterwards.
    task automatic run_vec(input int n, input vec_t v);
        string id;
        id = $sformatf("vec%0d", n);
        bus0.IF_REQ    = !v.is_mem;
        bus0.IF_ADDR   = v.addr;
        bus0.MEM_REQ   = v.is_mem;
        bus0.MEM_WE    = v.we;
        bus0.MEM_BE_N  = v.be_n;
        bus0.MEM_ADDR  = v.addr;
        bus0.MEM_WDATA = v.wdata;
        @(negedge CLK);
        chk({id, " idle ce_n"}, 32'(bus0.RAM_CE_N), 32'd0);
        chk({id, " idle we_n"}, 32'(bus0.RAM_WE_N), 32'(v.exp_we_n));
        chk({id, " idle be_n"}, 32'(bus0.RAM_BE_N), 32'(v.exp_be_n));
        chk({id, " idle paddr"}, 32'(bus0.RAM_PADDR), 32'(v.addr));
        step();
        @(negedge CLK);
        chk({id, " access busy"}, 32'(bus0.BUSY), 32'd1);
        chk({id, " access ce_n"}, 32'(bus0.RAM_CE_N), 32'd1);
        chk({id, " access ctrl we_n"}, 32'(wen_q[0]), 32'(v.exp_we_n));
        chk({id, " access dones"}, {30'd0, bus0.IF_DONE, bus0.MEM_DONE}, 32'd0);
        step();
        @(negedge CLK);
        chk({id, " resp ctrl we_n"}, 32'(wen_q[0]), 32'd1);
        chk({id, " resp if_done"}, 32'(bus0.IF_DONE), 32'(!v.is_mem));
        chk({id, " resp mem_done"}, 32'(bus0.MEM_DONE), 32'(v.is_mem));
        if (!v.we) begin
            if (v.is_mem) chk({id, " mem_rdata"}, bus0.MEM_RDATA, v.exp_rdata);
            else          chk({id, " if_rdata"}, bus0.IF_RDATA, v.exp_rdata);
        end
        step();
        bus0.IF_REQ  = 1'b0;
        bus0.MEM_REQ = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        bus0.IF_REQ = 1'b0; bus0.IF_ADDR = '0; bus0.MEM_REQ = 1'b0; bus0.MEM_WE = 1'b0;
        bus0.MEM_BE_N = 4'hF; bus0.MEM_ADDR = '0; bus0.MEM_WDATA = '0;
        bus1.IF_REQ = 1'b0; bus1.IF_ADDR = '0; bus1.MEM_REQ = 1'b0; bus1.MEM_WE = 1'b0;
        bus1.MEM_BE_N = 4'hF; bus1.MEM_ADDR = '0; bus1.MEM_WDATA = '0;

        //            is_mem we    be_n   addr        wdata         we_n  be_n   rdata
        vecs[0] = '{1'b0, 1'b0, 4'h0, 19'h00010, 32'h00000000, 1'b1, 4'h0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 4'hC, 19'h00020, 32'h12345678, 1'b0, 4'hC, 32'h00000000};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 19'h00020, 32'h00000000, 1'b1, 4'h0, 32'hAABB5678};
        vecs[3] = '{1'b1, 1'b1, 4'h0, 19'h00030, 32'h11111111, 1'b0, 4'h0, 32'h00000000};
        vecs[4] = '{1'b1, 1'b1, 4'h0, 19'h00031, 32'h22222222, 1'b0, 4'h0, 32'h00000000};
        vecs[5] = '{1'b1, 1'b0, 4'h0, 19'h00030, 32'h00000000, 1'b1, 4'h0, 32'h11111111};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 19'h00031, 32'h00000000, 1'b1, 4'h0, 32'h22222222};

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state of both instances
        @(negedge CLK);
        chk("rst busy0", 32'(bus0.BUSY), 32'd0);
        chk("rst ce_n0", 32'(bus0.RAM_CE_N), 32'd1);
        chk("rst we_n0", 32'(bus0.RAM_WE_N), 32'd1);
        chk("rst be_n0", 32'(bus0.RAM_BE_N), 32'hF);
        chk("rst dones0", {30'd0, bus0.IF_DONE, bus0.MEM_DONE}, 32'd0);
        chk("rst if_rdata0", bus0.IF_RDATA, 32'd0);
        chk("rst mem_rdata0", bus0.MEM_RDATA, 32'd0);
        chk("rst busy1", 32'(bus1.BUSY), 32'd0);
        chk("rst ce_n1", 32'(bus1.RAM_CE_N), 32'd1);
        step();

        for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

        // Fixed priority: simultaneous requests, MEM done at c2, IF done at c5
        bus0.IF_REQ = 1'b1; bus0.IF_ADDR = 19'h00010;
        bus0.MEM_REQ = 1'b1; bus0.MEM_WE = 1'b0; bus0.MEM_BE_N = 4'h0; bus0.MEM_ADDR = 19'h00020;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) bus0.MEM_REQ = 1'b0;
            if (c == 6) bus0.IF_REQ = 1'b0;
            @(negedge CLK);
            chk($sformatf("prio c%0d mem_done", c), 32'(bus0.MEM_DONE), 32'(c == 2));
            chk($sformatf("prio c%0d if_done", c), 32'(bus0.IF_DONE), 32'(c == 5));
            if (c == 2) chk("prio mem_rdata", bus0.MEM_RDATA, 32'hAABB5678);
            if (c == 5) chk("prio if_rdata", bus0.IF_RDATA, 32'hDEADBEEF);
            step();
        end

        // Round-robin: both held for four accesses, grants MEM, IF, MEM, IF
        bus1.IF_REQ = 1'b1; bus1.IF_ADDR = 19'h00010;
        bus1.MEM_REQ = 1'b1; bus1.MEM_WE = 1'b0; bus1.MEM_BE_N = 4'h0; bus1.MEM_ADDR = 19'h00020;
        for (int c = 0; c < 13; c++) begin
            if (c == 12) begin
                bus1.IF_REQ  = 1'b0;
                bus1.MEM_REQ = 1'b0;
            end
            @(negedge CLK);
            if (c < 12) begin
                chk($sformatf("rr c%0d mem_done", c), 32'(bus1.MEM_DONE),
                    32'(c == 2 || c == 8));
                chk($sformatf("rr c%0d if_done", c), 32'(bus1.IF_DONE),
                    32'(c == 5 || c == 11));
            end else begin
                chk("rr idle busy", 32'(bus1.BUSY), 32'd0);
            end
            if (c == 2) chk("rr mem_rdata", bus1.MEM_RDATA, 32'hAABBCCDD);
            if (c == 5) chk("rr if_rdata", bus1.IF_RDATA, 32'hDEADBEEF);
            step();
        end

        // Reset during ACCESS of an IF read: access abandoned, no DONE
        bus0.IF_REQ = 1'b1; bus0.IF_ADDR = 19'h00010;
        @(negedge CLK);
        chk("rstacc idle ce_n", 32'(bus0.RAM_CE_N), 32'd0);
        step();
        RST = 1'b1;
        bus0.IF_REQ = 1'b0;
        @(negedge CLK);
        chk("rstacc access busy", 32'(bus0.BUSY), 32'd1);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rstacc busy", 32'(bus0.BUSY), 32'd0);
        chk("rstacc ce_n", 32'(bus0.RAM_CE_N), 32'd1);
        chk("rstacc if_done", 32'(bus0.IF_DONE), 32'd0);
        chk("rstacc if_rdata", bus0.IF_RDATA, 32'd0);
        step();
        @(negedge CLK);
        chk("rstacc late if_done", 32'(bus0.IF_DONE), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
